// File: rtl/rl_pkg.sv
// Shared constants for the RL argmax selector: fp16 field layout, FSM state
// encoding and exploration LFSR parameters.
package rl_pkg;

    localparam int          FP_EXP   = 5;
    localparam int          FP_FRA   = 10;
    localparam int          FP_WIDTH = 1 + FP_EXP + FP_FRA;
    localparam logic [15:0] FP_QNAN  = 16'h7E00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_OUT   = 2'd2
    } state_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {cur[14:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/fp_cmp.sv
// Combinational fp16 comparator: sign-magnitude total order, +0 == -0,
// NaN below every number and equal to any other NaN.
module fp_cmp
    import rl_pkg::*;
#(
    parameter int EXP = FP_EXP,
    parameter int FRA = FP_FRA,
    localparam int W  = 1 + EXP + FRA
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         gt,
    output logic         eq
);

    function automatic logic is_nan(input logic [W-1:0] v);
        return (&v[W-2:FRA]) && (|v[FRA-1:0]);
    endfunction

    logic         a_nan_s;
    logic         b_nan_s;
    logic [W-2:0] mag_a_s;
    logic [W-2:0] mag_b_s;

    assign a_nan_s = is_nan(a);
    assign b_nan_s = is_nan(b);
    assign mag_a_s = a[W-2:0];
    assign mag_b_s = b[W-2:0];

    // Ordering decision, NaN and signed-zero cases first
    always_comb begin
        gt = 1'b0;
        eq = 1'b0;
        if (a_nan_s && b_nan_s) begin
            eq = 1'b1;
        end else if (a_nan_s) begin
            gt = 1'b0;
        end else if (b_nan_s) begin
            gt = 1'b1;
        end else if ((mag_a_s == {(W-1){1'b0}}) && (mag_b_s == {(W-1){1'b0}})) begin
            eq = 1'b1;
        end else if (a[W-1] != b[W-1]) begin
            gt = ~a[W-1];
        end else if (a[W-1]) begin
            gt = (mag_a_s < mag_b_s);
            eq = (mag_a_s == mag_b_s);
        end else begin
            gt = (mag_a_s > mag_b_s);
            eq = (mag_a_s == mag_b_s);
        end
    end

endmodule

// File: rtl/rl_argmax_select.sv
// Streaming greedy argmax over one frame of fp16 Q-values per result.
// Optional epsilon-greedy exploration is compiled in with RL_EXPLORE_EN.
module rl_argmax_select
    import rl_pkg::*;
#(
    parameter int  N_ACT = 4,
    parameter int  WIDTH = 16,
    parameter int  EXP   = 5,
    parameter int  FRA   = 10,
    localparam int IDX_W = (N_ACT > 1) ? $clog2(N_ACT) : 1,
    localparam int CNT_W = $clog2(N_ACT + 1)
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [IDX_W-1:0] m_index,
    output logic [WIDTH-1:0] m_qmax,
    output logic             m_equal,
    output logic             m_err
`ifdef RL_EXPLORE_EN
    ,
    input  logic [15:0]      eps_thresh,
    output logic             m_explore
`endif
);

    state_e             state_r, nxt_state_s;
    logic [WIDTH-1:0]   max_r, nxt_max_s;
    logic [IDX_W-1:0]   idx_r, nxt_idx_s, sel_idx_s;
    logic               tie_r, nxt_tie_s;
    logic [CNT_W-1:0]   cnt_r, nxt_cnt_s;
    logic               xfer_s, end_s, err_s, final_beat_s;
    logic               gt_s, eq_s;
    logic               m_valid_r, m_equal_r, m_err_r;
    logic [IDX_W-1:0]   m_index_r;
    logic [WIDTH-1:0]   m_qmax_r;

    // Gated by reset so the port reads 0 while reset is held
    assign s_ready = (state_r != ST_OUT) && !sys_rst;
    assign xfer_s  = s_valid && s_ready;

    fp_cmp #(.EXP(EXP), .FRA(FRA)) u_cmp (
        .a  (s_data),
        .b  (max_r),
        .gt (gt_s),
        .eq (eq_s)
    );

    // Next-state and running-maximum update
    always_comb begin
        nxt_state_s  = state_r;
        nxt_max_s    = max_r;
        nxt_idx_s    = idx_r;
        nxt_tie_s    = tie_r;
        nxt_cnt_s    = cnt_r;
        end_s        = 1'b0;
        err_s        = 1'b0;
        final_beat_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (xfer_s) begin
                    nxt_max_s   = s_data;
                    nxt_idx_s   = {IDX_W{1'b0}};
                    nxt_tie_s   = 1'b0;
                    nxt_cnt_s   = CNT_W'(1);
                    end_s       = s_last;
                    err_s       = s_last;
                    nxt_state_s = s_last ? ST_OUT : ST_ACCUM;
                end else begin
                    nxt_state_s = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (xfer_s) begin
                    if (gt_s) begin
                        nxt_max_s = s_data;
                        nxt_idx_s = cnt_r[IDX_W-1:0];
                        nxt_tie_s = 1'b0;
                    end else if (eq_s) begin
                        nxt_tie_s = 1'b1;
                    end else begin
                        nxt_tie_s = tie_r;
                    end
                    nxt_cnt_s    = cnt_r + CNT_W'(1);
                    final_beat_s = (nxt_cnt_s == CNT_W'(N_ACT));
                    end_s        = s_last || final_beat_s;
                    err_s        = s_last ^ final_beat_s;
                    nxt_state_s  = end_s ? ST_OUT : ST_ACCUM;
                end else begin
                    nxt_state_s = ST_ACCUM;
                end
            end
            ST_OUT: begin
                if (m_ready) begin
                    nxt_state_s = ST_IDLE;
                    nxt_cnt_s   = {CNT_W{1'b0}};
                end else begin
                    nxt_state_s = ST_OUT;
                end
            end
            default: begin
                nxt_state_s = ST_IDLE;
                nxt_cnt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

`ifdef RL_EXPLORE_EN
    logic [15:0]    lfsr_r;
    logic [IDX_W:0] rnd_ext_s;
    logic [IDX_W:0] n_act_ext_s;
    logic [IDX_W:0] rnd_red_s;
    logic           explore_s;
    logic           m_explore_r;

    assign explore_s   = (lfsr_r < eps_thresh);
    assign rnd_ext_s   = {1'b0, lfsr_r[IDX_W-1:0]};
    assign n_act_ext_s = (IDX_W + 1)'(N_ACT);
    assign rnd_red_s   = rnd_ext_s - n_act_ext_s;

    // Random action folded into 0..N_ACT-1 replaces the greedy pick when exploring
    always_comb begin
        if (explore_s && (rnd_ext_s >= n_act_ext_s)) begin
            sel_idx_s = rnd_red_s[IDX_W-1:0];
        end else if (explore_s) begin
            sel_idx_s = lfsr_r[IDX_W-1:0];
        end else begin
            sel_idx_s = nxt_idx_s;
        end
    end

    // LFSR steps once per accepted result
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            lfsr_r      <= LFSR_SEED;
            m_explore_r <= 1'b0;
        end else begin
            if (m_valid_r && m_ready) begin
                lfsr_r <= lfsr_next(lfsr_r);
            end
            if (end_s) begin
                m_explore_r <= explore_s;
            end
        end
    end

    assign m_explore = m_explore_r;
`else
    assign sel_idx_s = nxt_idx_s;
`endif

    // Frame state and registered result
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_r   <= ST_IDLE;
            max_r     <= {WIDTH{1'b0}};
            idx_r     <= {IDX_W{1'b0}};
            tie_r     <= 1'b0;
            cnt_r     <= {CNT_W{1'b0}};
            m_valid_r <= 1'b0;
            m_index_r <= {IDX_W{1'b0}};
            m_qmax_r  <= {WIDTH{1'b0}};
            m_equal_r <= 1'b0;
            m_err_r   <= 1'b0;
        end else begin
            state_r <= nxt_state_s;
            max_r   <= nxt_max_s;
            idx_r   <= nxt_idx_s;
            tie_r   <= nxt_tie_s;
            cnt_r   <= nxt_cnt_s;
            if (end_s) begin
                m_valid_r <= 1'b1;
                m_index_r <= sel_idx_s;
                m_qmax_r  <= nxt_max_s;
                m_equal_r <= nxt_tie_s;
                m_err_r   <= err_s;
            end else if (m_valid_r && m_ready) begin
                m_valid_r <= 1'b0;
            end
        end
    end

    assign m_valid = m_valid_r;
    assign m_index = m_index_r;
    assign m_qmax  = m_qmax_r;
    assign m_equal = m_equal_r;
    assign m_err   = m_err_r;

endmodule

// File: tb/tb_rl_argmax_select.sv
// Directed self-checking bench for rl_argmax_select (N_ACT=4, fp16).
module tb_rl_argmax_select;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [15:0] s_data  = 16'h0000;
    logic        s_last  = 1'b0;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [1:0]  m_index;
    logic [15:0] m_qmax;
    logic        m_equal;
    logic        m_err;
`ifdef RL_EXPLORE_EN
    logic [15:0] eps_thresh = 16'h0000;
    logic        m_explore;
    logic [15:0] lfsr_ref;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 sys_clk = ~sys_clk;

    rl_argmax_select #(.N_ACT(4), .WIDTH(16), .EXP(5), .FRA(10)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_last  (s_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_index (m_index),
        .m_qmax  (m_qmax),
        .m_equal (m_equal),
        .m_err   (m_err)
`ifdef RL_EXPLORE_EN
        ,
        .eps_thresh (eps_thresh),
        .m_explore  (m_explore)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic beat(input logic [15:0] d, input logic l);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        check("s_ready_beat", {31'd0, s_ready}, 32'd1);
        @(posedge sys_clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // d packs beat i in bits [16*i +: 16]
    task automatic frame(input logic [63:0] d, input int nb, input logic last_on_final);
        for (int i = 0; i < nb; i++) begin
            beat(d[16*i +: 16], last_on_final && (i == nb - 1));
        end
    endtask

    task automatic expect_result(input string tag, input logic [1:0] idx, input logic [15:0] q,
                                 input logic eq, input logic err);
        check({tag, "_valid"}, {31'd0, m_valid}, 32'd1);
        check({tag, "_index"}, {30'd0, m_index}, {30'd0, idx});
        check({tag, "_qmax"},  {16'd0, m_qmax},  {16'd0, q});
        check({tag, "_equal"}, {31'd0, m_equal}, {31'd0, eq});
        check({tag, "_err"},   {31'd0, m_err},   {31'd0, err});
        check({tag, "_sready"}, {31'd0, s_ready}, 32'd0);
    endtask

    task automatic handshake(input string tag);
        @(posedge sys_clk);
        #1;
        check({tag, "_drop"}, {31'd0, m_valid}, 32'd0);
        check({tag, "_idle_rdy"}, {31'd0, s_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1 sys_rst = 1'b1;
        #2;
        check("rst_valid", {31'd0, m_valid}, 32'd0);
        check("rst_sready", {31'd0, s_ready}, 32'd0);
        check("rst_index", {30'd0, m_index}, 32'd0);
        check("rst_qmax",  {16'd0, m_qmax},  32'd0);
        check("rst_equal", {31'd0, m_equal}, 32'd0);
        check("rst_err",   {31'd0, m_err},   32'd0);
        #19 sys_rst = 1'b0;
        #1;
        check("rst_first_ready", {31'd0, s_ready}, 32'd1);
        @(posedge sys_clk);
        #1;

        // 1.0, 2.0, -1.0, 0.5
        frame({16'h3800, 16'hBC00, 16'h4000, 16'h3C00}, 4, 1'b1);
        expect_result("basic", 2'd1, 16'h4000, 1'b0, 1'b0);
        handshake("basic");

        // repeated maximum keeps the lowest index
        frame({16'h4000, 16'h4000, 16'h3C00, 16'h4000}, 4, 1'b1);
        expect_result("tie", 2'd0, 16'h4000, 1'b1, 1'b0);
        handshake("tie");

        // NaN, -inf, NaN, -0
        frame({16'h8000, 16'h7E00, 16'hFC00, 16'h7E00}, 4, 1'b1);
        expect_result("nan", 2'd3, 16'h8000, 1'b0, 1'b0);
        handshake("nan");

        // -0 and +0 compare equal
        frame({16'hFC00, 16'hBC00, 16'h0000, 16'h8000}, 4, 1'b1);
        expect_result("zero", 2'd0, 16'h8000, 1'b1, 1'b0);
        handshake("zero");

        // all NaN payloads are mutually equal
        frame({16'h7E00, 16'hFE00, 16'h7C01, 16'h7E00}, 4, 1'b1);
        expect_result("allnan", 2'd0, 16'h7E00, 1'b1, 1'b0);
        handshake("allnan");

        // early last on beat 2
        frame({16'h0000, 16'h0000, 16'h4400, 16'h3C00}, 2, 1'b1);
        expect_result("short", 2'd1, 16'h4400, 1'b0, 1'b1);
        handshake("short");

        // four beats with no last; +inf wins after a signed-zero tie
        frame({16'h7C00, 16'hFC00, 16'h8000, 16'h0000}, 4, 1'b0);
        expect_result("nolast", 2'd3, 16'h7C00, 1'b0, 1'b1);
        handshake("nolast");

        // backpressure: result held, pending beat not consumed
        m_ready = 1'b0;
        frame({16'h3800, 16'hBC00, 16'h4000, 16'h3C00}, 4, 1'b1);
        s_valid = 1'b1;
        s_data  = 16'h7C00;
        s_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge sys_clk);
            #1;
            expect_result("hold", 2'd1, 16'h4000, 1'b0, 1'b0);
        end
        m_ready = 1'b1;
        @(posedge sys_clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        check("hold_drop", {31'd0, m_valid}, 32'd0);
        frame({16'h3C00, 16'h3C00, 16'h4200, 16'h3C00}, 4, 1'b1);
        expect_result("after_hold", 2'd1, 16'h4200, 1'b0, 1'b0);
        handshake("after_hold");

        // reset mid-frame after two beats
        frame({16'h0000, 16'h0000, 16'h4800, 16'h4800}, 2, 1'b0);
        #2 sys_rst = 1'b1;
        #1;
        check("midrst_valid", {31'd0, m_valid}, 32'd0);
        check("midrst_sready", {31'd0, s_ready}, 32'd0);
        #2 sys_rst = 1'b0;
        #1;
        check("midrst_ready", {31'd0, s_ready}, 32'd1);
        @(posedge sys_clk);
        #1;
        check("midrst_nopulse", {31'd0, m_valid}, 32'd0);
        frame({16'h0000, 16'h3800, 16'h4400, 16'h3C00}, 4, 1'b1);
        expect_result("post_rst", 2'd1, 16'h4400, 1'b0, 1'b0);
        handshake("post_rst");

`ifdef RL_EXPLORE_EN
        sys_rst = 1'b1;
        #2 sys_rst = 1'b0;
        @(posedge sys_clk);
        #1;
        lfsr_ref = 16'hACE1;
        eps_thresh = 16'h0000;
        for (int f = 0; f < 100; f++) begin
            frame({16'h3800, 16'hBC00, 16'h4000, 16'h3C00}, 4, 1'b1);
            check("eps0_explore", {31'd0, m_explore}, 32'd0);
            check("eps0_index", {30'd0, m_index}, 32'd1);
            handshake("eps0");
            lfsr_ref = {lfsr_ref[14:0], lfsr_ref[15] ^ lfsr_ref[13] ^ lfsr_ref[12] ^ lfsr_ref[10]};
        end
        eps_thresh = 16'hFFFF;
        for (int f = 0; f < 20; f++) begin
            frame({16'h3800, 16'hBC00, 16'h4000, 16'h3C00}, 4, 1'b1);
            check("epsmax_explore", {31'd0, m_explore}, {31'd0, (lfsr_ref < 16'hFFFF)});
            check("epsmax_index", {30'd0, m_index},
                  (lfsr_ref < 16'hFFFF) ? {30'd0, lfsr_ref[1:0]} : 32'd1);
            check("epsmax_qmax", {16'd0, m_qmax}, 32'h4000);
            handshake("epsmax");
            lfsr_ref = {lfsr_ref[14:0], lfsr_ref[15] ^ lfsr_ref[13] ^ lfsr_ref[12] ^ lfsr_ref[10]};
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/rl_argmax_select.md
RL_ARGMAX_SELECT -- requirements
Module: rl_argmax_select

Interface
REQ-001 Parameter N_ACT, default 4: number of Q-values (actions) per frame; legal range 2..256.
REQ-002 Parameter WIDTH, default 16: Q-value width, IEEE half precision.
REQ-003 Parameter EXP, default 5: exponent bits.
REQ-004 Parameter FRA, default 10: fraction bits; WIDTH SHALL equal 1+EXP+FRA.
REQ-005 Derived constant IDX_W = max(1, clog2(N_ACT)).
REQ-006 sys_clk  in  1  clock.
REQ-007 sys_rst  in  1  reset, asynchronous, active-high.
REQ-008 s_valid  in  1  Q-value beat valid.
REQ-009 s_ready  out  1  block accepts a beat.
REQ-010 s_data  in  WIDTH  Q-value, in action order 0..N_ACT-1.
REQ-011 s_last  in  1  final beat of frame.
REQ-012 m_valid  out  1  result valid.
REQ-013 m_ready  in  1  downstream accepts result.
REQ-014 m_index  out  IDX_W  selected action.
REQ-015 m_qmax  out  WIDTH  Q-value of the greedy maximum.
REQ-016 m_equal  out  1  greedy maximum occurred more than once.
REQ-017 m_err  out  1  frame length mismatch.

Function
REQ-018 The FSM SHALL have three states: IDLE, ACCUM and OUT.
REQ-019 s_ready SHALL be 1 in IDLE and ACCUM and 0 in OUT.
REQ-020 A beat transfers when s_valid&&s_ready.
REQ-021 In IDLE, a transfer SHALL load max=s_data, idx=0, tie=0, cnt=1 and move to ACCUM; if that beat carries s_last, the block SHALL go directly to OUT.
REQ-022 In ACCUM, a transfer with new>max SHALL set max=new, idx=cnt, tie=0.
REQ-023 In ACCUM, a transfer with new==max SHALL set tie=1; the lowest index is kept.
REQ-024 Every ACCUM transfer SHALL increment cnt.
REQ-025 A frame SHALL end on the beat with s_last or on the N_ACT-th beat, whichever comes first; the next cycle is OUT with m_valid=1.
REQ-026 The result latency SHALL be 1 cycle after the last transfer.
REQ-027 m_err=1 if s_last arrives before beat N_ACT, or if beat N_ACT lacks s_last.
REQ-028 The comparison SHALL be fp16 total order by sign-magnitude: -0 equals +0; infinities order normally.
REQ-029 A NaN (exp all ones, fraction nonzero) SHALL compare less than every non-NaN and equal to another NaN.
REQ-030 In OUT, outputs SHALL hold stable until m_ready.
REQ-031 m_valid&&m_ready SHALL return the FSM to IDLE; no beat is accepted in that cycle.
REQ-032 m_index, m_qmax, m_equal and m_err SHALL be registered.

Reset
REQ-033 Asserting sys_rst SHALL clear all outputs to 0 and set state=IDLE, cnt=0.
REQ-034 Reset mid-frame or in OUT SHALL discard the partial or pending result with no output pulse.
REQ-035 After reset deassertion, s_ready SHALL be 1 in the first clock.

Configuration
REQ-036 Macro RL_EXPLORE_EN SHALL compile in epsilon-greedy exploration.
REQ-037 With RL_EXPLORE_EN, the block SHALL add input eps_thresh[15:0] and output m_explore[1].
REQ-038 With RL_EXPLORE_EN, a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 at reset) SHALL advance once per completed output handshake.
REQ-039 With RL_EXPLORE_EN, on entering OUT, if lfsr<eps_thresh then m_index=r and m_explore=1, where r=lfsr[IDX_W-1:0], minus N_ACT if r>=N_ACT.
REQ-040 With RL_EXPLORE_EN, m_qmax, m_equal and m_err SHALL still report the greedy result.
REQ-041 Without RL_EXPLORE_EN, the ports, LFSR and exploration logic SHALL be absent and behaviour purely greedy.

Structure
REQ-042 Package rl_pkg SHALL hold the fp16 field constants (EXP, FRA, QNAN encoding), the state enum typedef, the LFSR seed and taps.
REQ-043 Sub-module fp_cmp SHALL be instanced once: combinational, (a,b) -> gt, eq, using the NaN rules above.

Verification
REQ-044 N_ACT=4, beats 0x3C00, 0x4000, 0xBC00, 0x3800 with last on beat 4, m_ready=1 -> m_valid one cycle later, m_index=1, m_qmax=0x4000, m_equal=0, m_err=0.
REQ-045 Beats 0x4000, 0x3C00, 0x4000, 0x4000 -> m_index=0, m_equal=1.
REQ-046 Beats 0x7E00, 0xFC00, 0x7E00, 0x8000 -> m_index=3, m_qmax=0x8000; -inf beats NaN, -0 beats -inf.
REQ-047 s_last on beat 2 of 0x3C00, 0x4400 -> m_index=1, m_err=1; 4 beats without last -> m_err=1.
REQ-048 m_ready held 0 for 5 cycles -> outputs stable, s_ready=0, beats not consumed; sys_rst pulsed mid-frame after 2 beats -> no m_valid, next frame correct.
REQ-049 With RL_EXPLORE_EN: eps_thresh=0 -> m_explore never set over 100 frames; eps_thresh=16'hFFFF -> m_explore=1 and m_index matches the LFSR reference model for every frame.
